seq_control: RTL and testbench
==============================

Name: seq_control

Overview:
- Multi-cycle, registered successor to the single-cycle accumulator-ISA control decoder.
- Accepts one instruction per handshake and sequences control strobes through an FSM.
- Stretches load/store strobes across a variable-latency data memory, with a timeout.
- Latches halt until reset. Sits between instruction fetch/PC logic and the datapath (accumulator, register file, data memory, lookup table).

Parameters:
- OP_W, 4: opcode width; must be >= 4. Values 0..14 are defined; 15 and above are reserved.
- MEM_TIMEOUT, 15: maximum cycles spent in MEM waiting for MemReady before abort; must be >= 1.
- CNT_W, 4: width of the MEM wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- Clk  in  1  clock, rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- InstValid  in  1  instruction present on TypeBit/OP.
- TypeBit  in  1  1 = branch-type instruction.
- OP  in  OP_W  opcode when TypeBit = 0.
- MemReady  in  1  data memory completes the current access.
- InstReady  out  1  control accepts an instruction this cycle.
- RegWrite, AccWrite, Branch, ReadMem, WriteMem, LookUp, of0, isMem  out  1 each  datapath strobes (registered).
- PCEnable  out  1  one-cycle pulse: retire and advance PC.
- Halt  out  1  sticky halted flag.
- MemError  out  1  one-cycle pulse on memory timeout.
- IllegalOp  out  1  one-cycle pulse on a reserved opcode.

Behaviour:
- Reset (async assert, sync deassert at the next edge): state = IDLE, wait counter = 0. Every output is 0 except InstReady = 1.
- States: IDLE, EXEC, MEM, HALT. InstReady = 1 only in IDLE.
- Accept: an instruction is accepted on a Clk edge in IDLE with InstValid = 1. TypeBit and OP are captured into an internal register.
- IDLE transitions on accept:
  - TypeBit = 1 -> EXEC.
  - OP = 2 or 3 -> MEM.
  - OP = 14 -> HALT.
  - any other OP -> EXEC.
  - InstValid = 0 -> stay in IDLE.
- EXEC (exactly 1 cycle, then IDLE):
  - Strobe decode per opcode: 0, 4..12 -> AccWrite; 1 -> RegWrite; 8 -> LookUp + AccWrite; 13 -> of0; TypeBit -> Branch.
  - PCEnable = 1.
  - Opcode 15 or above -> no strobes, PCEnable = 1, IllegalOp = 1 (trap behaviour: see Optional Feature).
- MEM:
  - Load (OP = 2): ReadMem = 1 and isMem = 1, held every cycle in MEM.
  - Store (OP = 3): WriteMem = 1, held every cycle in MEM.
  - Counter increments each MEM cycle in which MemReady = 0.
  - MemReady = 1 -> that same cycle: AccWrite = 1 (load only) and PCEnable = 1; next state IDLE; counter cleared.
  - Counter reaches MEM_TIMEOUT with MemReady = 0 -> the next cycle is the abort cycle: all strobes 0, MemError = 1, PCEnable = 1, then IDLE.
  - Simultaneous MemReady = 1 and counter = MEM_TIMEOUT: MemReady wins, no MemError.
- HALT:
  - Halt = 1; all other strobes and InstReady = 0. PCEnable is not pulsed.
  - Only Reset_n exits this state; InstValid is ignored.
- Strobe rules:
  - Strobes are functions of state plus the captured instruction only. The live OP/TypeBit inputs never drive them combinationally.
  - At most one of RegWrite/AccWrite is high in any cycle.
  - PCEnable is high exactly once per accepted non-halt instruction.
- Reset mid-MEM: strobes drop immediately (asynchronously); no AccWrite and no PCEnable are issued.

Optional Feature:
- Macro: SEQ_CONTROL_ILLEGAL_TRAP_EN.
- Defined: a reserved opcode goes IDLE -> HALT instead of EXEC. IllegalOp pulses for 1 cycle on HALT entry, Halt = 1, and PCEnable is not pulsed.
- Undefined: a reserved opcode executes as an EXEC no-op with PCEnable = 1 and IllegalOp = 1 for that cycle.

Test Plan:
- Reset, then accept OP = 11 -> next cycle AccWrite = 1 and PCEnable = 1 for exactly 1 cycle; InstReady = 0 that cycle; IDLE after.
- Load (OP = 2), MemReady held 0 for 3 cycles then 1 -> ReadMem and isMem high for 4 cycles; AccWrite and PCEnable high only in the 4th.
- Store (OP = 3), MEM_TIMEOUT = 15, MemReady stuck 0 -> WriteMem high for 15 cycles, then 1 abort cycle with MemError = 1, PCEnable = 1, WriteMem = 0; then IDLE.
- TypeBit = 1 with OP = 5 -> only Branch and PCEnable pulse; AccWrite stays 0.
- OP = 14, then InstValid = 1 for 10 cycles -> Halt stays 1, InstReady = 0, no PCEnable; Reset_n low mid-cycle -> Halt = 0 immediately, InstReady = 1.
- OP = 15 with and without SEQ_CONTROL_ILLEGAL_TRAP_EN -> HALT with IllegalOp pulse, versus EXEC no-op with IllegalOp = 1 and PCEnable = 1.

Source files
------------

// File: rtl/seq_control.sv
// Multi-cycle control sequencer for the accumulator ISA: accepts one instruction per handshake and steps its strobes through IDLE/EXEC/MEM/HALT.
// Optional macro SEQ_CONTROL_ILLEGAL_TRAP_EN: a reserved opcode halts the core instead of executing as a no-op.
module seq_control #(
    parameter int unsigned OP_W        = 4,
    parameter int unsigned MEM_TIMEOUT = 15,
    parameter int unsigned CNT_W       = 4
) (
    input  logic            Clk,
    input  logic            Reset_n,
    input  logic            InstValid,
    input  logic            TypeBit,
    input  logic [OP_W-1:0] OP,
    input  logic            MemReady,
    output logic            InstReady,
    output logic            RegWrite,
    output logic            AccWrite,
    output logic            Branch,
    output logic            ReadMem,
    output logic            WriteMem,
    output logic            LookUp,
    output logic            of0,
    output logic            isMem,
    output logic            PCEnable,
    output logic            Halt,
    output logic            MemError,
    output logic            IllegalOp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_MEM  = 2'd2,
        S_HALT = 2'd3
    } state_e;

    localparam logic [OP_W-1:0]  OP_ACC0     = OP_W'(0);
    localparam logic [OP_W-1:0]  OP_REG      = OP_W'(1);
    localparam logic [OP_W-1:0]  OP_LOAD     = OP_W'(2);
    localparam logic [OP_W-1:0]  OP_STORE    = OP_W'(3);
    localparam logic [OP_W-1:0]  OP_ACC_LO   = OP_W'(4);
    localparam logic [OP_W-1:0]  OP_LOOKUP   = OP_W'(8);
    localparam logic [OP_W-1:0]  OP_ACC_HI   = OP_W'(12);
    localparam logic [OP_W-1:0]  OP_OF0      = OP_W'(13);
    localparam logic [OP_W-1:0]  OP_HALT     = OP_W'(14);
    localparam logic [OP_W-1:0]  OP_RESERVED = OP_W'(15);
    localparam logic [CNT_W-1:0] CNT_MAX     = CNT_W'(MEM_TIMEOUT);

    state_e            state_q, state_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              type_q, type_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              illegal_q, illegal_d;
    logic              is_load;
    logic              mem_abort;

    // State, captured instruction, MEM wait counter and the one-shot illegal flag.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= S_IDLE;
            op_q      <= '0;
            type_q    <= 1'b0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            type_q    <= type_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
        end
    end

    assign is_load   = (op_q == OP_LOAD);
    assign mem_abort = !MemReady && (cnt_q == CNT_MAX);

    // Next state plus strobe decode from state and captured instruction only.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        type_d    = type_q;
        cnt_d     = '0;
        illegal_d = 1'b0;
        InstReady = 1'b0;
        RegWrite  = 1'b0;
        AccWrite  = 1'b0;
        Branch    = 1'b0;
        ReadMem   = 1'b0;
        WriteMem  = 1'b0;
        LookUp    = 1'b0;
        of0       = 1'b0;
        isMem     = 1'b0;
        PCEnable  = 1'b0;
        Halt      = 1'b0;
        MemError  = 1'b0;
        IllegalOp = illegal_q;

        case (state_q)
            S_IDLE: begin
                InstReady = 1'b1;
                if (InstValid) begin
                    op_d      = OP;
                    type_d    = TypeBit;
                    illegal_d = !TypeBit && (OP >= OP_RESERVED);
                    if (TypeBit) begin
                        state_d = S_EXEC;
                    end else if (OP == OP_LOAD || OP == OP_STORE) begin
                        state_d = S_MEM;
                    end else if (OP == OP_HALT) begin
                        state_d = S_HALT;
`ifdef SEQ_CONTROL_ILLEGAL_TRAP_EN
                    end else if (OP >= OP_RESERVED) begin
                        state_d = S_HALT;
`endif
                    end else begin
                        state_d = S_EXEC;
                    end
                end
            end

            S_EXEC: begin
                state_d  = S_IDLE;
                PCEnable = 1'b1;
                if (type_q) begin
                    Branch = 1'b1;
                end else begin
                    AccWrite = (op_q == OP_ACC0) ||
                               (op_q >= OP_ACC_LO && op_q <= OP_ACC_HI);
                    LookUp   = (op_q == OP_LOOKUP);
                    RegWrite = (op_q == OP_REG);
                    of0      = (op_q == OP_OF0);
                end
            end

            S_MEM: begin
                // The cycle with the counter at its limit is the abort cycle unless MemReady arrives.
                if (!mem_abort) begin
                    ReadMem  = is_load;
                    isMem    = is_load;
                    WriteMem = !is_load;
                end
                if (MemReady) begin
                    AccWrite = is_load;
                    PCEnable = 1'b1;
                    state_d  = S_IDLE;
                end else if (mem_abort) begin
                    MemError = 1'b1;
                    PCEnable = 1'b1;
                    state_d  = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_HALT: begin
                Halt = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_control.sv
// Directed self-checking bench for seq_control; expectations follow SEQ_CONTROL_ILLEGAL_TRAP_EN if defined.
module tb_seq_control;

    localparam int unsigned OP_W = 4;

    // Output vector bit positions: {InstReady,RegWrite,AccWrite,Branch,ReadMem,WriteMem,LookUp,of0,isMem,PCEnable,Halt,MemError,IllegalOp}
    localparam logic [12:0] IR = 13'b1_0000_0000_0000;
    localparam logic [12:0] RW = 13'b0_1000_0000_0000;
    localparam logic [12:0] AW = 13'b0_0100_0000_0000;
    localparam logic [12:0] BR = 13'b0_0010_0000_0000;
    localparam logic [12:0] RM = 13'b0_0001_0000_0000;
    localparam logic [12:0] WM = 13'b0_0000_1000_0000;
    localparam logic [12:0] LU = 13'b0_0000_0100_0000;
    localparam logic [12:0] O0 = 13'b0_0000_0010_0000;
    localparam logic [12:0] IM = 13'b0_0000_0001_0000;
    localparam logic [12:0] PC = 13'b0_0000_0000_1000;
    localparam logic [12:0] HL = 13'b0_0000_0000_0100;
    localparam logic [12:0] ME = 13'b0_0000_0000_0010;
    localparam logic [12:0] IL = 13'b0_0000_0000_0001;

    logic            clk;
    logic            rst_n;
    logic            inst_valid;
    logic            type_bit;
    logic [OP_W-1:0] op;
    logic            mem_ready;
    logic            inst_ready, reg_write, acc_write, branch, read_mem, write_mem;
    logic            look_up, of0, is_mem, pc_enable, halt, mem_error, illegal_op;
    logic [12:0]     outs;

    int checks = 0;
    int errors = 0;

    seq_control #(.OP_W(OP_W), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .Clk       (clk),
        .Reset_n   (rst_n),
        .InstValid (inst_valid),
        .TypeBit   (type_bit),
        .OP        (op),
        .MemReady  (mem_ready),
        .InstReady (inst_ready),
        .RegWrite  (reg_write),
        .AccWrite  (acc_write),
        .Branch    (branch),
        .ReadMem   (read_mem),
        .WriteMem  (write_mem),
        .LookUp    (look_up),
        .of0       (of0),
        .isMem     (is_mem),
        .PCEnable  (pc_enable),
        .Halt      (halt),
        .MemError  (mem_error),
        .IllegalOp (illegal_op)
    );

    assign outs = {inst_ready, reg_write, acc_write, branch, read_mem, write_mem,
                   look_up, of0, is_mem, pc_enable, halt, mem_error, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic tb, input int unsigned opc);
        inst_valid = 1'b1;
        type_bit   = tb;
        op         = OP_W'(opc);
        tick();
        inst_valid = 1'b0;
        type_bit   = 1'b0;
        op         = '0;
    endtask

    task automatic do_reset(input string tag);
        #2;
        rst_n = 1'b0;
        #1;
        check(tag, outs, IR);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n      = 1'b0;
        inst_valid = 1'b0;
        type_bit   = 1'b0;
        op         = '0;
        mem_ready  = 1'b0;
        #1;
        check("reset", outs, IR);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // ALU op: single EXEC cycle then back to IDLE
        issue(1'b0, 11);
        check("op11 exec", outs, AW | PC);
        tick();
        check("op11 idle", outs, IR);

        // Load with three wait cycles
        issue(1'b0, 2);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("load wait%0d", i), outs, RM | IM);
            tick();
        end
        mem_ready = 1'b1;
        #1;
        check("load done", outs, RM | IM | AW | PC);
        tick();
        mem_ready = 1'b0;
        check("load idle", outs, IR);

        // Store timing out
        issue(1'b0, 3);
        for (int i = 0; i < 15; i++) begin
            check($sformatf("store wait%0d", i), outs, WM);
            tick();
        end
        check("store abort", outs, ME | PC);
        tick();
        check("store idle", outs, IR);

        // MemReady on the limit cycle wins over the timeout
        issue(1'b0, 3);
        repeat (15) tick();
        mem_ready = 1'b1;
        #1;
        check("store late ready", outs, WM | PC);
        tick();
        mem_ready = 1'b0;
        check("store late idle", outs, IR);

        // Branch ignores the opcode decode
        issue(1'b1, 5);
        check("branch", outs, BR | PC);
        tick();
        check("branch idle", outs, IR);

        issue(1'b0, 8);
        check("lookup", outs, AW | LU | PC);
        tick();
        issue(1'b0, 1);
        check("regwrite", outs, RW | PC);
        tick();
        issue(1'b0, 13);
        check("of0", outs, O0 | PC);
        tick();
        issue(1'b0, 0);
        check("op0", outs, AW | PC);
        tick();
        issue(1'b0, 12);
        check("op12", outs, AW | PC);
        tick();

        // Reserved opcode
        issue(1'b0, 15);
`ifdef SEQ_CONTROL_ILLEGAL_TRAP_EN
        check("illegal trap", outs, HL | IL);
        tick();
        check("illegal trap hold", outs, HL);
`else
        check("illegal nop", outs, PC | IL);
        tick();
        check("illegal idle", outs, IR);
`endif
        do_reset("illegal reset");

        // Reset in the middle of a load drops strobes immediately
        issue(1'b0, 2);
        check("load mid", outs, RM | IM);
        do_reset("reset mid mem");
        check("after mem reset", outs, IR);

        // Halt is sticky and ignores further instructions
        issue(1'b0, 14);
        check("halt entry", outs, HL);
        inst_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op = OP_W'(i);
            tick();
            check($sformatf("halt hold%0d", i), outs, HL);
        end
        inst_valid = 1'b0;
        do_reset("halt reset");
        tick();
        check("post halt idle", outs, IR);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
